// File: rtl/log_lut_pkg.sv
// Shared types and constants for the log2/exp2 LUT loader and its skid FIFO.
package log_lut_pkg;

  localparam int FLOAT_LEN = 16;
  localparam int MANT_LEN  = 10;
  localparam int LUT_SIZE  = 128;
  localparam int CNT_W     = $clog2(LUT_SIZE) + 1;
  localparam logic [CNT_W-1:0] LUT_SIZE_CNT = CNT_W'(LUT_SIZE);

  typedef struct packed {
    logic [MANT_LEN-1:0]  log2;
    logic [FLOAT_LEN-1:0] exp2;
  } lut_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } load_state_e;

  function automatic logic is_busy(input load_state_e s);
    return (s == FILL) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/lut_entry_fifo.sv
// Small synchronous FIFO of LUT entries; decouples host stalls from the write port.
module lut_entry_fifo import log_lut_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  lut_entry_t wdata,
  input  logic       pop,
  output lut_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;
  lut_entry_t       mem_q [DEPTH];

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1'b1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/log_lut_loader.sv
// Streams exactly LUT_SIZE log2/exp2 entries from a valid/ready host into the
// log-scale unit's LUT write port, one registered write beat per entry.
module log_lut_loader import log_lut_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MANT_LEN-1:0]  in_log2,
  input  logic [FLOAT_LEN-1:0] in_exp2,
  output logic                 lut_wr_en,
  output logic [MANT_LEN-1:0]  log2_lut_data_out,
  output logic [FLOAT_LEN-1:0] exp2_lut_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 lut_loaded
);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             lut_wr_en_q, lut_wr_en_d, busy_q, busy_d;
  logic             done_q, done_d, lut_loaded_q, lut_loaded_d;
  lut_entry_t       data_q, data_d, push_entry_s, pop_entry_s;
  logic             fifo_full_s, fifo_empty_s, accept_s, pop_s, in_ready_s;

  assign push_entry_s = '{log2: in_log2, exp2: in_exp2};

  lut_entry_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (pop_entry_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // DRAIN exits on the next wr_cnt so done lands right after the last beat.
  always_comb begin
    in_ready_s   = (state_q == FILL) && !fifo_full_s && (acc_cnt_q < LUT_SIZE_CNT);
    accept_s     = in_valid && in_ready_s;
    pop_s        = is_busy(state_q) && !fifo_empty_s;
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q + {{(CNT_W-1){1'b0}}, accept_s};
    wr_cnt_d     = wr_cnt_q + {{(CNT_W-1){1'b0}}, lut_wr_en_q};
    lut_wr_en_d  = pop_s;
    data_d       = pop_s ? pop_entry_s : data_q;
    done_d       = 1'b0;
    lut_loaded_d = lut_loaded_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FILL;
          acc_cnt_d    = '0;
          wr_cnt_d     = '0;
          lut_loaded_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (acc_cnt_q == LUT_SIZE_CNT) state_d = DRAIN;
        else                           state_d = FILL;
      end
      DRAIN: begin
        if (wr_cnt_d == LUT_SIZE_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d      = IDLE;
        lut_loaded_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      lut_wr_en_q  <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lut_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      lut_wr_en_q  <= lut_wr_en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lut_loaded_q <= lut_loaded_d;
    end
  end

  assign in_ready          = in_ready_s;
  assign lut_wr_en         = lut_wr_en_q;
  assign log2_lut_data_out = data_q.log2;
  assign exp2_lut_data_out = data_q.exp2;
  assign busy              = busy_q;
  assign done              = done_q;
  assign lut_loaded        = lut_loaded_q;

endmodule
